// File: rtl/jtag_1149_d10_mstr_rsp_packer_if.sv
// Beat input bus and FWFT read port of the master scan-response packer.
// The slave modport is the packer; the master modport is the surrounding logic.
interface jtag_1149_d10_mstr_rsp_packer_if #(
  parameter int unsigned SCAN_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
);
  logic [SCAN_WIDTH-1:0] rsp_data;
  logic [BE_WIDTH-1:0]   rsp_data_be;
  logic                  rsp_data_vld;
  logic [SCAN_WIDTH-1:0] out_data;
  logic [BE_WIDTH-1:0]   out_be;
  logic                  out_vld;
  logic                  out_rdy;

  modport slave (
    input  rsp_data, rsp_data_be, rsp_data_vld, out_rdy,
    output out_data, out_be, out_vld
  );

  modport master (
    output rsp_data, rsp_data_be, rsp_data_vld, out_rdy,
    input  out_data, out_be, out_vld
  );
endinterface

// File: rtl/jtag_1149_d10_mstr_rsp_packer.sv
// Compacts byte-enabled scan-response beats into full 32-bit words and buffers
// them in a first-word-fall-through FIFO, with flush, overflow flag and drop counter.
module jtag_1149_d10_mstr_rsp_packer #(
  parameter int unsigned SCAN_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_AW        = 4,
  parameter int unsigned ERR_CNTR_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  jtag_1149_d10_mstr_rsp_packer_if.slave rsp_if,
  input  logic                           flush,
  input  logic                           soft_clr,
  output logic [FIFO_AW:0]               fifo_level,
  output logic                           ovf_sticky,
  output logic [ERR_CNTR_WIDTH-1:0]      drop_cnt,
  output logic [1:0]                     acc_cnt
);

  localparam int unsigned EW = SCAN_WIDTH + BE_WIDTH;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [7:0]                acc_q [3];
  logic [1:0]                acc_cnt_q;
  logic                      flush_pend_q;
  logic [EW-1:0]             mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]          level_q;
  logic [SCAN_WIDTH-1:0]     out_data_q;
  logic [BE_WIDTH-1:0]       out_be_q;
  logic                      ovf_q;
  logic [ERR_CNTR_WIDTH-1:0] drop_q;

  logic [7:0]         cb [7];
  logic [2:0]         pos, total;
  logic               pend, full, pop, push_req, push, drop;
  logic [EW-1:0]      push_word, head_n;
  logic [7:0]         acc_n [3];
  logic [1:0]         acc_cnt_n;
  logic               flush_pend_n;
  logic [FIFO_AW:0]   level_n, lvl_after_pop;
  logic [FIFO_AW-1:0] rd_n;
  logic [3:0]         flush_be;

  // Resident bytes sit at the bottom of cb; enabled beat bytes are appended
  // in ascending index order. Unused accumulator bytes are kept at zero.
  always_comb begin
    for (int unsigned i = 0; i < 7; i++) cb[i] = '0;
    for (int unsigned i = 0; i < 3; i++) cb[i] = acc_q[i];
    pos = {1'b0, acc_cnt_q};
    for (int unsigned i = 0; i < 4; i++) begin
      if (rsp_if.rsp_data_vld && rsp_if.rsp_data_be[i]) begin
        cb[pos] = rsp_if.rsp_data[8*i +: 8];
        pos     = pos + 3'd1;
      end
    end
    total = pos;
  end

  always_comb begin
    case (acc_cnt_q)
      2'd1:    flush_be = 4'b0001;
      2'd2:    flush_be = 4'b0011;
      2'd3:    flush_be = 4'b0111;
      default: flush_be = 4'b0000;
    endcase
  end

  always_comb begin
    pend         = flush_pend_q | flush;
    pop          = (level_q != '0) && rsp_if.out_rdy;
    full         = (level_q == LVL_FULL);
    push_req     = 1'b0;
    push_word    = '0;
    acc_n        = acc_q;
    acc_cnt_n    = acc_cnt_q;
    flush_pend_n = pend;
    if (rsp_if.rsp_data_vld) begin
      if (total >= 3'd4) begin
        push_req  = 1'b1;
        push_word = {4'hF, cb[3], cb[2], cb[1], cb[0]};
        acc_n[0]  = cb[4];
        acc_n[1]  = cb[5];
        acc_n[2]  = cb[6];
        acc_cnt_n = 2'(total - 3'd4);
      end else begin
        acc_n[0]  = cb[0];
        acc_n[1]  = cb[1];
        acc_n[2]  = cb[2];
        acc_cnt_n = total[1:0];
      end
    end else if (pend) begin
      flush_pend_n = 1'b0;
      if (acc_cnt_q != 2'd0) begin
        push_req  = 1'b1;
        push_word = {flush_be, 8'h00, acc_q[2], acc_q[1], acc_q[0]};
        for (int unsigned i = 0; i < 3; i++) acc_n[i] = '0;
        acc_cnt_n = 2'd0;
      end
    end
    // A dropped beat or flush leaves the accumulator exactly as it was.
    drop = push_req && full && !pop;
    if (drop) begin
      acc_n     = acc_q;
      acc_cnt_n = acc_cnt_q;
    end
    push = push_req && !drop;

    level_n       = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    lvl_after_pop = level_q - (FIFO_AW+1)'(pop);
    rd_n          = rd_ptr_q + FIFO_AW'(pop);
    // The next head is the incoming word only when nothing older survives the pop.
    head_n        = (lvl_after_pop == '0) ? push_word : mem[rd_n];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || soft_clr) begin
      acc_q        <= '{default: '0};
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      acc_q        <= acc_n;
      acc_cnt_q    <= acc_cnt_n;
      flush_pend_q <= flush_pend_n;
      level_q      <= level_n;
      rd_ptr_q     <= rd_n;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (level_n != '0) {out_be_q, out_data_q} <= head_n;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + ERR_CNTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && rst_n && !soft_clr) mem[wr_ptr_q] <= push_word;
  end

  assign rsp_if.out_data = out_data_q;
  assign rsp_if.out_be   = out_be_q;
  assign rsp_if.out_vld  = (level_q != '0);
  assign fifo_level      = level_q;
  assign ovf_sticky      = ovf_q;
  assign drop_cnt        = drop_q;
  assign acc_cnt         = acc_cnt_q;

endmodule

// File: tb/tb_jtag_1149_d10_mstr_rsp_packer.sv
// Directed bench for the response packer: byte-queue reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_jtag_1149_d10_mstr_rsp_packer;
  logic        clk = 1'b0;
  logic        rst_n, flush, soft_clr;
  logic [4:0]  fifo_level;
  logic        ovf_sticky;
  logic [15:0] drop_cnt;
  logic [1:0]  acc_cnt;

  always #5 clk = ~clk;

  jtag_1149_d10_mstr_rsp_packer_if #(.SCAN_WIDTH(32), .BE_WIDTH(4)) bus ();

  jtag_1149_d10_mstr_rsp_packer #(
    .SCAN_WIDTH(32), .BE_WIDTH(4), .FIFO_DEPTH(16), .FIFO_AW(4), .ERR_CNTR_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsp_if     (bus),
    .flush      (flush),
    .soft_clr   (soft_clr),
    .fifo_level (fifo_level),
    .ovf_sticky (ovf_sticky),
    .drop_cnt   (drop_cnt),
    .acc_cnt    (acc_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accumulator as a byte queue, FIFO as a word queue {be,data}.
  logic [7:0]  m_acc [$];
  logic [35:0] m_q [$];
  logic        m_pend = 1'b0;
  logic        m_ovf  = 1'b0;
  int          m_drop = 0;
  logic [35:0] m_hold = '0;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0]  tmp [$];
    logic [35:0] w;
    bit          do_push, pop, full, dropped;
    started = 1'b1;
    if (!rst_n || soft_clr) begin
      m_acc.delete();
      m_q.delete();
      m_pend = 1'b0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_hold = '0;
    end else begin
      full    = (m_q.size() == 16);
      pop     = (m_q.size() > 0) && bus.out_rdy;
      do_push = 1'b0;
      dropped = 1'b0;
      w       = '0;
      if (bus.rsp_data_vld) begin
        tmp = m_acc;
        for (int i = 0; i < 4; i++)
          if (bus.rsp_data_be[i]) tmp.push_back(bus.rsp_data[8*i +: 8]);
        m_pend = m_pend | flush;
        if (tmp.size() >= 4) begin
          w = {4'hF, tmp[3], tmp[2], tmp[1], tmp[0]};
          if (full && !pop) dropped = 1'b1;
          else begin
            do_push = 1'b1;
            m_acc.delete();
            for (int i = 4; i < tmp.size(); i++) m_acc.push_back(tmp[i]);
          end
        end else begin
          m_acc = tmp;
        end
      end else if (m_pend || flush) begin
        m_pend = 1'b0;
        if (m_acc.size() > 0) begin
          for (int i = 0; i < m_acc.size(); i++) begin
            w[8*i +: 8] = m_acc[i];
            w[32+i]     = 1'b1;
          end
          if (full && !pop) dropped = 1'b1;
          else begin
            do_push = 1'b1;
            m_acc.delete();
          end
        end
      end
      if (dropped) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(w);
      if (m_q.size() > 0) m_hold = m_q[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_vld",    bus.out_vld, (m_q.size() > 0));
      chk("out_word",   {bus.out_be, bus.out_data}, m_hold);
      chk("fifo_level", fifo_level, m_q.size());
      chk("acc_cnt",    acc_cnt, m_acc.size());
      chk("ovf_sticky", ovf_sticky, m_ovf);
      chk("drop_cnt",   drop_cnt, m_drop);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] be);
    bus.rsp_data     = d;
    bus.rsp_data_be  = be;
    bus.rsp_data_vld = 1'b1;
    cyc();
    bus.rsp_data_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; soft_clr = 1'b0;
    bus.rsp_data = '0; bus.rsp_data_be = '0; bus.rsp_data_vld = 1'b0; bus.out_rdy = 1'b0;
    cyc(); cyc();
    chk("rst_vld", bus.out_vld, 1'b0);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_be", bus.out_be, 4'h0);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_acc", acc_cnt, 2'd0);
    chk("rst_ovf", ovf_sticky, 1'b0);
    chk("rst_drop", drop_cnt, 16'd0);
    rst_n = 1'b1;

    // Full beats stream straight through, one cycle latency.
    bus.out_rdy = 1'b1;
    beat(32'h03020100, 4'hF); chk("w0", {bus.out_be, bus.out_data}, 36'hF_03020100);
    beat(32'h07060504, 4'hF); chk("w1", {bus.out_be, bus.out_data}, 36'hF_07060504);
    beat(32'h0B0A0908, 4'hF); chk("w2", {bus.out_be, bus.out_data}, 36'hF_0B0A0908);
    cyc();
    chk("drained_vld", bus.out_vld, 1'b0);
    chk("hold_data", bus.out_data, 32'h0B0A0908);

    // Sparse enables: AA,CC then 22,33,44 -> word 3322CCAA, 0x44 left over.
    bus.out_rdy = 1'b0;
    beat(32'hDDCCBBAA, 4'b0101);
    beat(32'h44332211, 4'b1110);
    chk("sparse_word", {bus.out_be, bus.out_data}, 36'hF_3322CCAA);
    chk("sparse_acc", acc_cnt, 2'd1);
    flush = 1'b1; bus.out_rdy = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_word", {bus.out_be, bus.out_data}, 36'h1_00000044);
    chk("flush_acc", acc_cnt, 2'd0);
    cyc();

    // Flush coincident with a beat executes on the next idle cycle.
    bus.rsp_data = 32'h12345678; bus.rsp_data_be = 4'b0011; bus.rsp_data_vld = 1'b1; flush = 1'b1;
    cyc();
    bus.rsp_data_vld = 1'b0; flush = 1'b0;
    chk("coinc_acc", acc_cnt, 2'd2);
    chk("coinc_vld", bus.out_vld, 1'b0);
    cyc();
    chk("coinc_word", {bus.out_be, bus.out_data}, 36'h3_00005678);
    cyc();

    // be=0000 is a no-op; be=1010 takes bytes 1 and 3.
    beat(32'hFFFFFFFF, 4'b0000);
    chk("be0_acc", acc_cnt, 2'd0);
    beat(32'hD4C3B2A1, 4'b1010);
    beat(32'hD4C3B2A1, 4'b1010);
    chk("be1010_word", {bus.out_be, bus.out_data}, 36'hF_D4B2D4B2);
    cyc();

    // Overflow: 17 beats into a stalled FIFO.
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 17; i++) beat(32'h10000000 + i, 4'hF);
    chk("ovf_level", fifo_level, 5'd16);
    chk("ovf_flag", ovf_sticky, 1'b1);
    chk("ovf_drop", drop_cnt, 16'd1);
    chk("ovf_head", bus.out_data, 32'h10000000);
    // Full with simultaneous pop and push: no drop, pointers wrap.
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) beat(32'h20000000 + i, 4'hF);
    chk("pp_level", fifo_level, 5'd16);
    chk("pp_drop", drop_cnt, 16'd1);
    for (int k = 0; k < 16; k++) begin
      chk("drain_order", bus.out_data, (k < 12) ? 32'h10000004 + k : 32'h20000000 + (k - 12));
      cyc();
    end
    chk("drain_vld", bus.out_vld, 1'b0);

    // Flush into a full FIFO is dropped and keeps the accumulator.
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) beat(32'h50000000 + i, 4'hF);
    beat(32'h000000EE, 4'b0001);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fovf_drop", drop_cnt, 16'd2);
    chk("fovf_acc", acc_cnt, 2'd1);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    chk("fovf_nopend", bus.out_vld, 1'b0);

    // Reset mid-stream with acc_cnt=2 and level=5.
    soft_clr = 1'b1; cyc(); soft_clr = 1'b0;
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'h30000000 + i, 4'hF);
    beat(32'h0000BEEF, 4'b0011);
    chk("mid_level", fifo_level, 5'd5);
    chk("mid_acc", acc_cnt, 2'd2);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("mid_rst_vld", bus.out_vld, 1'b0);
    chk("mid_rst_level", fifo_level, 5'd0);
    chk("mid_rst_acc", acc_cnt, 2'd0);
    bus.out_rdy = 1'b1;
    beat(32'h44332211, 4'hF);
    chk("post_rst_word", bus.out_data, 32'h44332211);
    cyc();

    // soft_clr discards a beat in the same cycle.
    beat(32'h0000CAFE, 4'b0011);
    bus.rsp_data = 32'h99999999; bus.rsp_data_be = 4'hF; bus.rsp_data_vld = 1'b1; soft_clr = 1'b1;
    cyc();
    bus.rsp_data_vld = 1'b0; soft_clr = 1'b0;
    chk("sclr_acc", acc_cnt, 2'd0);
    chk("sclr_vld", bus.out_vld, 1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
